mips_instr_encoder_loader: RTL

//  Inverse of the P5 instruction decoder: takes symbolic instruction requests (op + fields)
//  and encodes each into a 32-bit MIPS word, then writes it word-by-word into instruction memory.

---
 rtl/mips_instr_encoder_loader_pkg.sv | 53 +++++
 rtl/mips_instr_encoder_loader_encode.sv | 39 +++
 rtl/mips_instr_encoder_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mips_instr_encoder_loader_pkg.sv
// Shared opcode/funct constants, request op codes and FSM state type for the program loader.
package mips_instr_encoder_loader_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_JALR   = 6'h09;
   localparam logic [5:0] FN_ADDU   = 6'h21;
   localparam logic [5:0] FN_SUBU   = 6'h23;

   localparam logic [3:0] ENC_NOP   = 4'd0;
   localparam logic [3:0] ENC_ADDU  = 4'd1;
   localparam logic [3:0] ENC_SUBU  = 4'd2;
   localparam logic [3:0] ENC_JR    = 4'd3;
   localparam logic [3:0] ENC_JALR  = 4'd4;
   localparam logic [3:0] ENC_ORI   = 4'd5;
   localparam logic [3:0] ENC_LUI   = 4'd6;
   localparam logic [3:0] ENC_LW    = 4'd7;
   localparam logic [3:0] ENC_SW    = 4'd8;
   localparam logic [3:0] ENC_BEQ   = 4'd9;
   localparam logic [3:0] ENC_J     = 4'd10;
   localparam logic [3:0] ENC_JAL   = 4'd11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WRITE  = 3'd2,
      ST_VERIFY = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] target);
      return {opc, target};
   endfunction

endpackage

// File: rtl/mips_instr_encoder_loader_encode.sv
// Combinational encoder: symbolic request fields -> 32-bit MIPS word; unknown ops give 0 + bad_op.
module mips_instr_encode
   import mips_instr_encoder_loader_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        bad_op
);

   // Field packing per request op; unused register fields are forced to zero
   always_comb begin
      word   = 32'h0000_0000;
      bad_op = 1'b0;
      case (op)
         ENC_NOP:  word = 32'h0000_0000;
         ENC_ADDU: word = pack_r(rs, rt, rd, FN_ADDU);
         ENC_SUBU: word = pack_r(rs, rt, rd, FN_SUBU);
         ENC_JR:   word = pack_r(rs, 5'd0, 5'd0, FN_JR);
         ENC_JALR: word = pack_r(rs, 5'd0, rd, FN_JALR);
         ENC_ORI:  word = pack_i(OPC_ORI, rs, rt, imm);
         ENC_LUI:  word = pack_i(OPC_LUI, 5'd0, rt, imm);
         ENC_LW:   word = pack_i(OPC_LW, rs, rt, imm);
         ENC_SW:   word = pack_i(OPC_SW, rs, rt, imm);
         ENC_BEQ:  word = pack_i(OPC_BEQ, rs, rt, imm);
         ENC_J:    word = pack_j(OPC_J, target);
         ENC_JAL:  word = pack_j(OPC_JAL, target);
         default: begin
            word   = 32'h0000_0000;
            bad_op = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder_loader.sv
// Program loader: encodes symbolic MIPS requests and writes them word-by-word into IM.
// Build option ENCODER_READBACK_EN adds a two-cycle VERIFY read-back after every write.
module mips_instr_encoder_loader
   import mips_instr_encoder_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   input  logic [15:0] req_imm,
   input  logic [25:0] req_target,
   input  logic        req_last,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   input  logic [31:0] im_rdata,
   output logic        busy,
   output logic        done,
   output logic [10:0] count,
   output logic        overflow,
   output logic        bad_op,
   output logic        mismatch
);

   localparam logic [10:0] DEPTH_W = 11'(DEPTH);

   state_t      state_r,    state_s;
   logic [31:0] ptr_r,      ptr_s;
   logic [10:0] count_r,    count_s;
   logic [31:0] wdata_r,    wdata_s;
   logic        last_r,     last_s;
   logic        overflow_r, overflow_s;
   logic        bad_op_r,   bad_op_s;
   logic        ready_s;
   logic        we_s;
   logic        full_s;
   logic [31:0] enc_word_s;
   logic        enc_bad_s;
`ifdef ENCODER_READBACK_EN
   logic        vcnt_r,     vcnt_s;
   logic        mismatch_r, mismatch_s;
`else
   logic        unused_rdata_s;
`endif

   mips_instr_encode u_encode (
      .op     (req_op),
      .rs     (req_rs),
      .rt     (req_rt),
      .rd     (req_rd),
      .imm    (req_imm),
      .target (req_target),
      .word   (enc_word_s),
      .bad_op (enc_bad_s)
   );

   assign full_s = (count_r == DEPTH_W);

   // Next-state, datapath updates and strobes; start overrides everything and opens a new session
   always_comb begin
      state_s    = state_r;
      ptr_s      = ptr_r;
      count_s    = count_r;
      wdata_s    = wdata_r;
      last_s     = last_r;
      overflow_s = overflow_r;
      bad_op_s   = bad_op_r;
      ready_s    = 1'b0;
      we_s       = 1'b0;
`ifdef ENCODER_READBACK_EN
      vcnt_s     = vcnt_r;
      mismatch_s = mismatch_r;
`endif
      if (start) begin
         state_s    = ST_LOAD;
         ptr_s      = BASE_ADDR;
         count_s    = 11'd0;
         last_s     = 1'b0;
         overflow_s = 1'b0;
         bad_op_s   = 1'b0;
`ifdef ENCODER_READBACK_EN
         vcnt_s     = 1'b0;
         mismatch_s = 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: state_s = ST_IDLE;
            ST_LOAD: begin
               ready_s = ~full_s;
               if (req_valid && full_s) begin
                  overflow_s = 1'b1;
                  state_s    = ST_DONE;
               end else if (req_valid) begin
                  wdata_s  = enc_word_s;
                  last_s   = req_last;
                  bad_op_s = bad_op_r | enc_bad_s;
                  state_s  = ST_WRITE;
               end else begin
                  state_s = ST_LOAD;
               end
            end
            ST_WRITE: begin
               we_s    = 1'b1;
               count_s = count_r + 11'd1;
`ifdef ENCODER_READBACK_EN
               vcnt_s  = 1'b0;
               state_s = ST_VERIFY;
`else
               ptr_s   = ptr_r + 32'd4;
               state_s = last_r ? ST_DONE : ST_LOAD;
`endif
            end
`ifdef ENCODER_READBACK_EN
            // im_addr stays on the written word; read data is valid in the second cycle
            ST_VERIFY: begin
               if (!vcnt_r) begin
                  vcnt_s = 1'b1;
               end else begin
                  mismatch_s = mismatch_r | (im_rdata != wdata_r);
                  ptr_s      = ptr_r + 32'd4;
                  state_s    = last_r ? ST_DONE : ST_LOAD;
               end
            end
`endif
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         ptr_r      <= BASE_ADDR;
         count_r    <= 11'd0;
         wdata_r    <= 32'h0000_0000;
         last_r     <= 1'b0;
         overflow_r <= 1'b0;
         bad_op_r   <= 1'b0;
`ifdef ENCODER_READBACK_EN
         vcnt_r     <= 1'b0;
         mismatch_r <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         ptr_r      <= ptr_s;
         count_r    <= count_s;
         wdata_r    <= wdata_s;
         last_r     <= last_s;
         overflow_r <= overflow_s;
         bad_op_r   <= bad_op_s;
`ifdef ENCODER_READBACK_EN
         vcnt_r     <= vcnt_s;
         mismatch_r <= mismatch_s;
`endif
      end
   end

   assign req_ready = ready_s;
   assign im_we     = we_s;
   assign im_addr   = (state_r == ST_IDLE) ? 32'h0000_0000 : ptr_r;
   assign im_wdata  = wdata_r;
   assign busy      = (state_r == ST_LOAD) || (state_r == ST_WRITE) || (state_r == ST_VERIFY);
   assign done      = (state_r == ST_DONE);
   assign count     = count_r;
   assign overflow  = overflow_r;
   assign bad_op    = bad_op_r;
`ifdef ENCODER_READBACK_EN
   assign mismatch  = mismatch_r;
`else
   assign mismatch       = 1'b0;
   assign unused_rdata_s = ^im_rdata;
`endif

endmodule
